i2c_reg_slave: RTL and testbench

I2C target (responder) with an internal 8-bit register file, synchronous to `sys_clk`. It is the far end of the codec-configuration I2C writer, and it stands in for the codec in simulation benches. It also serves any on-chip block that must accept register writes over I2C. It decodes START/STOP, matches its 7-bit address, ACKs, accepts a register pointer followed by write bytes, and serves read bytes, with pointer auto-increment.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_bus_sync.sv | 43 ++++
 rtl/i2c_reg_slave.sv | 172 +++++++++++++++++
 tb/tb_i2c_reg_slave.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
// State encoding, default address and ACK levels.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } i2c_state_t;

  localparam logic [6:0] DEF_ADDR = 7'h40;
  localparam logic       ACK      = 1'b0;
  localparam logic       NACK     = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into sys_clk and flags bus edges,
// START and STOP conditions as one-cycle pulses.
module i2c_bus_sync (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_p;
  logic       sda_p;
  logic       scl_s;

  // Idle bus is high, so reset to 1 to avoid a fake edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_p  <= 1'b1;
      sda_p  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda};
      scl_p  <= scl_ff[1];
      sda_p  <= sda_ff[1];
    end
  end

  assign scl_s     = scl_ff[1];
  assign sda_s     = sda_ff[1];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C target with an 8-bit register file, pointer
// auto-increment, and a write-strobe side channel.
module i2c_reg_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEF_ADDR,
  parameter int         REG_DEPTH  = 32
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic                         scl,
  inout  wire                          sda,
  output logic                         wr_en,
  output logic [7:0]                   wr_addr,
  output logic [7:0]                   wr_data,
  output logic                         busy,
  input  logic [$clog2(REG_DEPTH)-1:0] dbg_addr,
  output logic [7:0]                   dbg_data
);

  localparam int AW = $clog2(REG_DEPTH);

  i2c_state_t    state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    rx_byte;
  logic [AW-1:0] ptr;
  logic [7:0]    regs [REG_DEPTH];
  logic          sda_oe;
  logic          sda_s;
  logic          scl_rise;
  logic          scl_fall;
  logic          start_det;
  logic          stop_det;
  logic          last;

  i2c_bus_sync u_sync (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign sda      = sda_oe ? 1'b0 : 1'bz;
  assign dbg_data = regs[dbg_addr];
  assign rx_byte  = {shreg[6:0], sda_s};
  assign last     = (bit_cnt == 4'd7);

  // In ACK states sda_oe doubles as the phase flag:
  // first fall starts the drive, second fall ends it.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
    end else begin
      wr_en <= 1'b0;
      if (stop_det) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= '0;
      end else if (start_det) begin
        state   <= ADDR;
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
      end else if (scl_rise) begin
        case (state)
          ADDR: begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 1'b1;
            if (last) state <= ADDR_ACK;
          end
          REG: begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 1'b1;
            if (last) begin
              ptr   <= rx_byte[AW-1:0];
              state <= REG_ACK;
            end
          end
          WDATA: begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 1'b1;
            if (last) begin
              regs[ptr] <= rx_byte;
              wr_en     <= 1'b1;
              wr_addr   <= 8'(ptr);
              wr_data   <= rx_byte;
              ptr       <= ptr + 1'b1;
              state     <= WDATA_ACK;
            end
          end
          RDATA: bit_cnt <= bit_cnt + 1'b1;
          RDATA_ACK: begin
            if (sda_s == ACK) begin
              ptr     <= ptr + 1'b1;
              bit_cnt <= 4'd1;
            end else begin
              state <= WAIT_STOP;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR_ACK: begin
            if (!sda_oe) begin
              if (shreg[7:1] == SLAVE_ADDR) begin
                sda_oe <= 1'b1;
                busy   <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              bit_cnt <= '0;
              if (shreg[0]) begin
                state  <= RDATA;
                shreg  <= regs[ptr];
                sda_oe <= ~regs[ptr][7];
              end else begin
                state  <= REG;
                sda_oe <= 1'b0;
              end
            end
          end
          REG_ACK, WDATA_ACK: begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= WDATA;
            end
          end
          RDATA: begin
            if (bit_cnt == 4'd8) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= RDATA_ACK;
            end else begin
              shreg  <= {shreg[6:0], 1'b0};
              sda_oe <= ~shreg[6];
            end
          end
          RDATA_ACK: begin
            if (bit_cnt == 4'd1) begin
              shreg   <= regs[ptr];
              sda_oe  <= ~regs[ptr][7];
              bit_cnt <= '0;
              state   <= RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bus-level master tasks drive a
// register-file model; writes and reads are checked against it.
module tb_i2c_reg_slave;

  localparam int Q = 10;

  typedef logic [7:0] byte_q_t[$];

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       scl     = 1'b1;
  logic       m_low   = 1'b0;
  wire        sda;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [4:0] dbg_addr = '0;
  logic [7:0] dbg_data;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 sys_clk = ~sys_clk;

  i2c_reg_slave #(
    .SLAVE_ADDR (7'h40),
    .REG_DEPTH  (32)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda      (sda),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  mreg [32];
  int          mptr = 0;
  logic [15:0] exp_q [$];

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic qw;
    repeat (Q) @(negedge sys_clk);
  endtask

  task automatic bus_start;
    m_low = 1'b0; qw;
    scl = 1'b1;   qw;
    m_low = 1'b1; qw;
    scl = 1'b0;   qw;
  endtask

  task automatic bus_stop;
    m_low = 1'b1; qw;
    scl = 1'b1;   qw;
    m_low = 1'b0; qw;
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; qw;
    scl = 1'b1; qw;
    qw;
    scl = 1'b0; qw;
  endtask

  task automatic recv_bit(output logic b);
    m_low = 1'b0; qw;
    scl = 1'b1;   qw;
    b = sda;      qw;
    scl = 1'b0;   qw;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(input logic ackb, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    send_bit(ackb);
  endtask

  task automatic wr_txn(input logic [6:0] a, input logic [7:0] p,
                        input byte_q_t data);
    logic ack;
    bus_start;
    write_byte({a, 1'b0}, ack);
    chk("addr_ack", ack, (a == 7'h40) ? 0 : 1);
    chk("busy_addr", busy, (a == 7'h40) ? 1 : 0);
    if (a == 7'h40) begin
      write_byte(p, ack);
      chk("reg_ack", ack, 0);
      mptr = p % 32;
      foreach (data[i]) begin
        mreg[mptr] = data[i];
        exp_q.push_back({mptr[7:0], data[i]});
        write_byte(data[i], ack);
        chk("data_ack", ack, 0);
        mptr = (mptr + 1) % 32;
      end
    end
    bus_stop;
    chk("busy_stop", busy, 0);
    chk("sda_idle", sda, 1);
  endtask

  task automatic rd_txn(input logic set_ptr, input logic [7:0] p,
                        input int n);
    logic       ack;
    logic [7:0] d;
    bus_start;
    if (set_ptr) begin
      write_byte(8'h80, ack);
      chk("rd_addr_w", ack, 0);
      write_byte(p, ack);
      chk("rd_reg_ack", ack, 0);
      mptr = p % 32;
      bus_start;
    end
    write_byte(8'h81, ack);
    chk("rd_addr_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      read_byte((i == n - 1), d);
      chk("rd_data", d, mreg[mptr]);
      if (i < n - 1) mptr = (mptr + 1) % 32;
    end
    chk("sda_rel_nack", sda, 1);
    bus_stop;
    chk("busy_rd_stop", busy, 0);
  endtask

  task automatic sweep;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk("dbg_data", dbg_data, mreg[i]);
    end
  endtask

  task automatic peek(input logic [4:0] a, input logic [7:0] v);
    dbg_addr = a;
    #1;
    chk("pin_reg", dbg_data, v);
  endtask

  function automatic byte_q_t rnd_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    logic       ack;
    logic [7:0] d;
    byte_q_t    q;
    for (int i = 0; i < 32; i++) mreg[i] = '0;

    fork
      forever begin
        @(negedge sys_clk);
        if (rst_n && wr_en) begin
          if (exp_q.size() == 0) begin
            chk("wr_en_unexp", wr_en, 0);
          end else begin
            d = exp_q[0][15:8];
            chk("wr_addr", wr_addr, d);
            chk("wr_data", wr_data, exp_q[0][7:0]);
            void'(exp_q.pop_front());
          end
        end
      end
    join_none

    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_sda", sda, 1);
    repeat (5) @(negedge sys_clk);
    rst_n = 1'b1;
    qw;
    sweep;

    q = '{8'h11};
    wr_txn(7'h40, 8'h1A, q);
    peek(5'h1A, 8'h11);

    q = '{};
    wr_txn(7'h41, 8'h00, q);
    sweep;

    q = '{8'hAA, 8'hBB};
    wr_txn(7'h40, 8'h1F, q);
    peek(5'h1F, 8'hAA);
    peek(5'h00, 8'hBB);

    q = '{8'h5C, 8'hE7};
    wr_txn(7'h40, 8'h03, q);
    bus_start;
    write_byte(8'h80, ack);
    chk("rs_addr_ack", ack, 0);
    write_byte(8'h03, ack);
    chk("rs_reg_ack", ack, 0);
    bus_start;
    write_byte(8'h81, ack);
    chk("rs_rd_ack", ack, 0);
    read_byte(1'b0, d);
    chk("pin_rd3", d, 8'h5C);
    read_byte(1'b1, d);
    chk("pin_rd4", d, 8'hE7);
    chk("rs_sda_rel", sda, 1);
    bus_stop;
    chk("rs_busy", busy, 0);
    mptr = 4;

    bus_start;
    write_byte(8'h80, ack);
    chk("part_addr_ack", ack, 0);
    write_byte(8'h07, ack);
    chk("part_reg_ack", ack, 0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    bus_stop;
    qw;
    chk("part_sda", sda, 1);
    chk("part_busy", busy, 0);
    mptr = 7;
    rd_txn(1'b0, 8'h00, 2);
    q = rnd_bytes(2);
    wr_txn(7'h40, 8'h07, q);
    sweep;

    for (int k = 0; k < 6; k++) begin
      q = rnd_bytes(1 + int'($urandom_range(3)));
      wr_txn(7'h40, 8'($urandom), q);
      rd_txn(1'b1, 8'($urandom), 1 + int'($urandom_range(2)));
      if (k % 2 == 1) rd_txn(1'b0, 8'h00, 2);
    end
    sweep;

    bus_start;
    for (int i = 6; i >= 0; i--) send_bit(1'(7'h40 >> i));
    send_bit(1'b0);
    m_low = 1'b0; qw;
    scl = 1'b1;   qw;
    chk("ack_drive", sda, 0);
    rst_n = 1'b0;
    #1;
    chk("rr_sda", sda, 1);
    chk("rr_wr_en", wr_en, 0);
    chk("rr_busy", busy, 0);
    chk("rr_wr_addr", wr_addr, 0);
    chk("rr_wr_data", wr_data, 0);
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    mptr = 0;
    exp_q.delete();
    qw;
    scl = 1'b0;
    qw;
    rst_n = 1'b1;
    qw;
    sweep;
    q = rnd_bytes(3);
    wr_txn(7'h40, 8'h10, q);
    rd_txn(1'b1, 8'h10, 3);
    sweep;

    qw;
    chk("wr_pending", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
